// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline.
// Issues req/gnt/rvalid data-memory transactions, builds byte enables and
// replicated store lanes, aligns and extends load data, flags misaligned
// accesses, stalls upstream while an access is outstanding, and owns the
// MEM/WB pipeline register.
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_mem_valid,
    input  logic [XLEN-1:0] ex_mem_alu_result,
    input  logic [XLEN-1:0] ex_mem_store_data,
    input  logic            ex_mem_mem_read,
    input  logic            ex_mem_mem_write,
    input  logic [2:0]      ex_mem_funct3,
    input  logic [4:0]      ex_mem_rd,
    input  logic            ex_mem_reg_write,
    input  logic [1:0]      ex_mem_wb_mux_sel,
    input  logic [XLEN-1:0] ex_mem_pc_plus_4,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_stall,
    output logic            mem_misaligned,
    output logic            mem_wb_valid,
    output logic            mem_wb_reg_write,
    output logic [4:0]      mem_wb_rd,
    output logic [1:0]      mem_wb_wb_mux_sel,
    output logic [XLEN-1:0] mem_wb_alu_result,
    output logic [XLEN-1:0] mem_wb_pc_plus_4,
    output logic [XLEN-1:0] dmem_read_data
);

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_WAIT_GNT    = 2'd1;
    localparam logic [1:0] ST_WAIT_RVALID = 2'd2;

    // Byte enables for the access size; the shift walks the lane mask
    // across the word by the byte offset.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane so the byte enables alone
    // select where it lands.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] sd);
        case (size)
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    // Pull the addressed byte/half down to bit 0 and extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] rdata, input logic [1:0] off,
                                                 input logic [2:0] f3);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h000000, sh[7:0]};
            3'b101:  return {16'h0000, sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic            mem_op_s;
    logic            misaligned_s;
    logic            issue_s;
    logic            req_s;
    logic            stall_s;
    logic            load_done_s;
    logic [1:0]      byte_off_s;

    logic            misaligned_r;
    logic            wb_valid_r;
    logic            wb_reg_write_r;
    logic [4:0]      wb_rd_r;
    logic [1:0]      wb_mux_sel_r;
    logic [XLEN-1:0] wb_alu_result_r;
    logic [XLEN-1:0] wb_pc_plus_4_r;
    logic [XLEN-1:0] read_data_r;

    assign byte_off_s = ex_mem_alu_result[1:0];
    assign mem_op_s   = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);

    // Halfwords must be 2-byte aligned and words 4-byte aligned; other sizes are never flagged.
    always_comb begin
        misaligned_s = 1'b0;
        case (ex_mem_funct3[1:0])
            2'b01:   misaligned_s = byte_off_s[0];
            2'b10:   misaligned_s = (byte_off_s != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
    end

    assign issue_s = mem_op_s & ~misaligned_s;

    // Handshake FSM: decides request, stall and the next state.
    always_comb begin
        state_nxt_s = state_r;
        req_s       = 1'b0;
        stall_s     = 1'b0;
        load_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) begin
                    req_s = 1'b1;
                    if (dmem_gnt) begin
                        if (ex_mem_mem_write) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_WAIT_RVALID;
                            stall_s     = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_WAIT_GNT;
                        stall_s     = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_GNT: begin
                req_s   = 1'b1;
                stall_s = 1'b1;
                if (dmem_gnt) begin
                    if (ex_mem_mem_write) begin
                        state_nxt_s = ST_IDLE;
                        stall_s     = 1'b0;
                    end else begin
                        state_nxt_s = ST_WAIT_RVALID;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_GNT;
                end
            end
            ST_WAIT_RVALID: begin
                stall_s = ~dmem_rvalid;
                if (dmem_rvalid) begin
                    state_nxt_s = ST_IDLE;
                    load_done_s = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_RVALID;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any outstanding access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // MEM/WB register: bubble while stalled, squash rd write on misaligned ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_r    <= 1'b0;
            wb_valid_r      <= 1'b0;
            wb_reg_write_r  <= 1'b0;
            wb_rd_r         <= 5'd0;
            wb_mux_sel_r    <= 2'd0;
            wb_alu_result_r <= {XLEN{1'b0}};
            wb_pc_plus_4_r  <= {XLEN{1'b0}};
            read_data_r     <= {XLEN{1'b0}};
        end else begin
            wb_rd_r         <= ex_mem_rd;
            wb_mux_sel_r    <= ex_mem_wb_mux_sel;
            wb_alu_result_r <= ex_mem_alu_result;
            wb_pc_plus_4_r  <= ex_mem_pc_plus_4;
            misaligned_r    <= (state_r == ST_IDLE) & mem_op_s & misaligned_s;
            if (stall_s) begin
                wb_valid_r     <= 1'b0;
                wb_reg_write_r <= 1'b0;
            end else begin
                wb_valid_r     <= ex_mem_valid;
                wb_reg_write_r <= ex_mem_valid & ex_mem_reg_write & ~(mem_op_s & misaligned_s);
            end
            if (load_done_s) begin
                read_data_r <= extract_load(dmem_rdata, byte_off_s, ex_mem_funct3);
            end else begin
                read_data_r <= {XLEN{1'b0}};
            end
        end
    end

    // Request and stall are forced low while reset is held.
    assign dmem_req   = req_s & rst_n;
    assign mem_stall  = stall_s & rst_n;
    assign dmem_we    = ex_mem_mem_write;
    assign dmem_addr  = {ex_mem_alu_result[XLEN-1:2], 2'b00};
    assign dmem_be    = store_be(ex_mem_funct3[1:0], byte_off_s);
    assign dmem_wdata = store_lanes(ex_mem_funct3[1:0], ex_mem_store_data);

    assign mem_misaligned    = misaligned_r;
    assign mem_wb_valid      = wb_valid_r;
    assign mem_wb_reg_write  = wb_reg_write_r;
    assign mem_wb_rd         = wb_rd_r;
    assign mem_wb_wb_mux_sel = wb_mux_sel_r;
    assign mem_wb_alu_result = wb_alu_result_r;
    assign mem_wb_pc_plus_4  = wb_pc_plus_4_r;
    assign dmem_read_data    = read_data_r;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized testbench for mem_stage with a transaction-level reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_mem_valid;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_store_data;
    logic        ex_mem_mem_read;
    logic        ex_mem_mem_write;
    logic [2:0]  ex_mem_funct3;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_reg_write;
    logic [1:0]  ex_mem_wb_mux_sel;
    logic [31:0] ex_mem_pc_plus_4;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        mem_misaligned;
    logic        mem_wb_valid;
    logic        mem_wb_reg_write;
    logic [4:0]  mem_wb_rd;
    logic [1:0]  mem_wb_wb_mux_sel;
    logic [31:0] mem_wb_alu_result;
    logic [31:0] mem_wb_pc_plus_4;
    logic [31:0] dmem_read_data;

    int n_vec = 0;
    int n_err = 0;
    int req_seen;
    int stall_seen;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_valid(ex_mem_valid), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_store_data(ex_mem_store_data), .ex_mem_mem_read(ex_mem_mem_read),
        .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_funct3(ex_mem_funct3),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
        .ex_mem_wb_mux_sel(ex_mem_wb_mux_sel), .ex_mem_pc_plus_4(ex_mem_pc_plus_4),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .mem_misaligned(mem_misaligned),
        .mem_wb_valid(mem_wb_valid), .mem_wb_reg_write(mem_wb_reg_write),
        .mem_wb_rd(mem_wb_rd), .mem_wb_wb_mux_sel(mem_wb_wb_mux_sel),
        .mem_wb_alu_result(mem_wb_alu_result), .mem_wb_pc_plus_4(mem_wb_pc_plus_4),
        .dmem_read_data(dmem_read_data)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: load value from the raw word using byte arithmetic.
    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [2:0] f3);
        int unsigned w, off, b, h, div;
        w   = rdata;
        off = addr % 4;
        div = 32'd1 << (8 * off);
        b   = (w / div) % 256;
        h   = (w / div) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned size;
        size = f3 % 4;
        return (size == 1 && (addr % 2) != 0) || (size == 2 && (addr % 4) != 0);
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned size, off;
        size = f3 % 4;
        off  = addr % 4;
        if (size == 0) return 4'(1 << off);
        if (size == 1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int unsigned size;
        size = f3 % 4;
        if (size == 0) return (sd % 256) * 32'h0101_0101;
        if (size == 1) return (sd % 65536) * 32'h0001_0001;
        return sd;
    endfunction

    // One instruction through MEM: g cycles before gnt, r empty cycles before rvalid.
    task automatic run_txn(input logic v, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                           input logic rw, input logic [1:0] sel, input logic [31:0] pc4,
                           input int g, input int r, input logic [31:0] rdata);
        bit mem_op, mis, issue, is_load, last, exp_req, exp_stall;
        int ncyc;
        mem_op  = v && (rd_en || wr_en);
        mis     = mem_op && ref_misaligned(f3, addr);
        issue   = mem_op && !mis;
        is_load = issue && !wr_en;
        if (!issue)      ncyc = 1;
        else if (wr_en)  ncyc = g + 1;
        else             ncyc = g + r + 2;
        ex_mem_valid = v; ex_mem_mem_read = rd_en; ex_mem_mem_write = wr_en;
        ex_mem_funct3 = f3; ex_mem_alu_result = addr; ex_mem_store_data = sdata;
        ex_mem_rd = rd; ex_mem_reg_write = rw; ex_mem_wb_mux_sel = sel; ex_mem_pc_plus_4 = pc4;
        req_seen = 0; stall_seen = 0;
        for (int c = 0; c < ncyc; c++) begin
            last       = (c == ncyc - 1);
            exp_req    = issue && (c <= g);
            exp_stall  = issue && (wr_en ? (c < g) : !last);
            dmem_gnt   = issue && (c == g);
            // rvalid outside the response window must be ignored
            dmem_rvalid = (is_load && last) ? 1'b1 : ((c <= g) ? 1'($urandom % 2) : 1'b0);
            dmem_rdata  = (is_load && last) ? rdata : $urandom;
            @(negedge clk);
            if (dmem_req)  req_seen++;
            if (mem_stall) stall_seen++;
            check("req", dmem_req, exp_req);
            check("stall", mem_stall, exp_stall);
            if (exp_req) begin
                check("addr", dmem_addr, addr & 32'hFFFF_FFFC);
                check("we", dmem_we, wr_en);
                check("be", dmem_be, ref_be(f3, addr));
                if (wr_en) check("wdata", dmem_wdata, ref_wdata(f3, sdata));
            end
            @(posedge clk);
            #1;
            if (exp_stall) begin
                check("bubble_valid", mem_wb_valid, 1'b0);
                check("bubble_rw", mem_wb_reg_write, 1'b0);
            end else begin
                check("wb_valid", mem_wb_valid, v);
                check("wb_rw", mem_wb_reg_write, v && rw && !mis);
                check("wb_rd", mem_wb_rd, rd);
                check("wb_sel", mem_wb_wb_mux_sel, sel);
                check("wb_alu", mem_wb_alu_result, addr);
                check("wb_pc4", mem_wb_pc_plus_4, pc4);
            end
            check("rdata", dmem_read_data, (is_load && last) ? ref_load(rdata, addr, f3) : 32'h0);
            check("misaligned", mem_misaligned, last && mis);
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3;
        logic       ld, st, vv;
        rst_n = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        // drive a valid load during reset: no request or stall may escape
        ex_mem_valid = 1'b1; ex_mem_mem_read = 1'b1; ex_mem_mem_write = 1'b0;
        ex_mem_funct3 = 3'd2; ex_mem_alu_result = 32'h100; ex_mem_store_data = 32'h0;
        ex_mem_rd = 5'd3; ex_mem_reg_write = 1'b1; ex_mem_wb_mux_sel = 2'd1;
        ex_mem_pc_plus_4 = 32'h44;
        #12;
        check("rst_req", dmem_req, 1'b0);
        check("rst_stall", mem_stall, 1'b0);
        check("rst_valid", mem_wb_valid, 1'b0);
        check("rst_rw", mem_wb_reg_write, 1'b0);
        check("rst_rdata", dmem_read_data, 32'h0);
        check("rst_alu", mem_wb_alu_result, 32'h0);
        check("rst_mis", mem_misaligned, 1'b0);
        ex_mem_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU op
        run_txn(1'b1, 1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 5'd5, 1'b1, 2'd0, 32'h8, 0, 0, 32'h0);
        check("alu_lit_result", mem_wb_alu_result, 32'h1234);
        check("alu_lit_rd", mem_wb_rd, 5'd5);
        // SB at 0x1003
        run_txn(1'b1, 1'b0, 1'b1, 3'd0, 32'h1003, 32'hAABBCCDD, 5'd0, 1'b0, 2'd0, 32'h10, 0, 0, 32'h0);
        check("sb_stall_cycles", stall_seen, 0);
        // LH / LHU at 0x2002
        run_txn(1'b1, 1'b1, 1'b0, 3'd1, 32'h2002, 32'h0, 5'd6, 1'b1, 2'd1, 32'h14, 0, 0, 32'h8001_0000);
        check("lh_lit", dmem_read_data, 32'hFFFF8001);
        check("lh_stall_cycles", stall_seen, 1);
        run_txn(1'b1, 1'b1, 1'b0, 3'd5, 32'h2002, 32'h0, 5'd7, 1'b1, 2'd1, 32'h18, 0, 0, 32'h8001_0000);
        check("lhu_lit", dmem_read_data, 32'h00008001);
        // LW with gnt withheld 3 cycles, two empty cycles before rvalid
        run_txn(1'b1, 1'b1, 1'b0, 3'd2, 32'h2400, 32'h0, 5'd8, 1'b1, 2'd1, 32'h1C, 3, 2, 32'hCAFE_F00D);
        check("lw_req_cycles", req_seen, 4);
        check("lw_stall_cycles", stall_seen, 6);
        check("lw_lit", dmem_read_data, 32'hCAFE_F00D);
        // misaligned LW
        run_txn(1'b1, 1'b1, 1'b0, 3'd2, 32'h3001, 32'h0, 5'd9, 1'b1, 2'd1, 32'h20, 0, 0, 32'h0);
        check("mis_lit", mem_misaligned, 1'b1);

        // reset while waiting for rvalid
        ex_mem_valid = 1'b1; ex_mem_mem_read = 1'b1; ex_mem_mem_write = 1'b0;
        ex_mem_funct3 = 3'd2; ex_mem_alu_result = 32'h40; ex_mem_rd = 5'd10; ex_mem_reg_write = 1'b1;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        check("wr_stall_before_rst", mem_stall, 1'b1);
        rst_n = 1'b0;
        #1;
        check("wr_rst_req", dmem_req, 1'b0);
        check("wr_rst_stall", mem_stall, 1'b0);
        check("wr_rst_valid", mem_wb_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ex_mem_valid = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        check("late_stall", mem_stall, 1'b0);
        check("late_req", dmem_req, 1'b0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        check("late_valid", mem_wb_valid, 1'b0);
        check("late_rdata", dmem_read_data, 32'h0);
        run_txn(1'b1, 1'b0, 1'b0, 3'd0, 32'h55, 32'h0, 5'd11, 1'b1, 2'd2, 32'h60, 0, 0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            int k;
            k  = $urandom_range(0, 9);
            vv = ($urandom_range(0, 7) != 0);
            ld = (k < 4);
            st = (k >= 4 && k < 7);
            if (ld) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            run_txn(vv, ld, st, f3, $urandom, $urandom, 5'($urandom), 1'($urandom),
                    2'($urandom_range(0, 2)), $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 2), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
